// File: rtl/jk_down_counter.sv
// Reloadable down counter built from per-bit JK cells; all state changes on the falling edge of clk.
// Load and decrement take effect at the edge where they are sampled. There is no backpressure: en gates counting.

module jk_cell (
    input  logic clk,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(negedge clk) begin
        case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
        endcase
    end
endmodule

module jk_down_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             one_shot,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             borrow,
    output logic             done
);
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             at_one;
    logic             hold_zero;
    logic             wrap;

    assign zero      = (q == '0);
    assign at_one    = (q == WIDTH'(1));
    assign hold_zero = en & one_shot & zero;
    assign wrap      = en & ~one_shot & zero;

    // Bit i toggles when every lower bit is 0, which is where a borrow propagates through.
    assign t[0] = en;
    for (genvar i = 1; i < WIDTH; i++) begin : g_toggle
        assign t[i] = en & ~(|q[i-1:0]);
    end

    // Reset and load are expressed as forced J/K values, so the cells stay plain JK flops.
    always_comb begin
        j = t;
        k = t;
        if (rst) begin
            j = '0;
            k = '1;
        end else if (load) begin
            j = load_val;
            k = ~load_val;
        end else if (hold_zero) begin
            j = '0;
            k = '0;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .j   (j[i]),
            .k   (k[i]),
            .q   (q[i])
        );
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            borrow <= 1'b0;
            done   <= 1'b0;
        end else if (load) begin
            borrow <= 1'b0;
            done   <= 1'b0;
        end else begin
            borrow <= wrap;
            if (en & one_shot & (zero | at_one)) begin
                done <= 1'b1;
            end
        end
    end
endmodule
